// File: rtl/lfsr8_seq_monitor.sv
// Sequence monitor for the 3-bit, 8-state self-correcting LFSR counter.
// Syncs on state 100, predicts each next state, reports lock/errors/wraps and the measured period.
module lfsr8_seq_monitor #(
    parameter int LOCK_CNT = 8,  // legal range 2..15
    parameter int ERR_W    = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_x2,
    input  logic             i_x1,
    input  logic             i_x0,
    output logic             o_lock,
    output logic             o_err,
    output logic             o_wrap,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [3:0]       o_period
);

    typedef enum logic [1:0] {
        SEEK,
        TRACK,
        LOCKED
    } state_t;

    localparam logic [2:0] SYNC_STATE  = 3'b100;
    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);
    localparam logic [3:0] CNT_MAX     = 4'd15;

    // Counter feedback: shift right, MSB fed with NOR(X2,X1) ^ X1 ^ X0.
    function automatic logic [2:0] lfsr_next(input logic [2:0] s);
        logic f;
        f = ~(s[2] | s[1]) ^ s[1] ^ s[0];
        return {f, s[2], s[1]};
    endfunction

    state_t           r_state,     w_state_nx;
    logic [2:0]       r_pred,      w_pred_nx;
    logic [3:0]       r_match_cnt, w_match_cnt_nx;
    logic [3:0]       r_samp_cnt,  w_samp_cnt_nx;
    logic             r_lock,      w_lock_nx;
    logic             r_err,       w_err_nx;
    logic             r_wrap,      w_wrap_nx;
    logic [ERR_W-1:0] r_err_cnt,   w_err_cnt_nx;
    logic [3:0]       r_period,    w_period_nx;

    logic [2:0]       w_sample;
    logic             w_hit;
    logic             w_is_sync;
    logic [3:0]       w_match_inc;
    logic [3:0]       w_samp_inc;
    logic [ERR_W-1:0] w_err_cnt_inc;

    assign w_sample      = {i_x2, i_x1, i_x0};
    assign w_hit         = (w_sample == r_pred);
    assign w_is_sync     = (w_sample == SYNC_STATE);
    assign w_match_inc   = r_match_cnt + 4'd1;
    assign w_samp_inc    = (r_samp_cnt == CNT_MAX) ? CNT_MAX : r_samp_cnt + 4'd1;
    assign w_err_cnt_inc = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + ERR_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch behind.
        w_state_nx     = r_state;
        w_pred_nx      = r_pred;
        w_match_cnt_nx = r_match_cnt;
        w_samp_cnt_nx  = r_samp_cnt;
        w_lock_nx      = r_lock;
        w_err_nx       = 1'b0;
        w_wrap_nx      = 1'b0;
        w_err_cnt_nx   = r_err_cnt;
        w_period_nx    = r_period;

        if (i_en) begin
            unique case (r_state)
                SEEK: begin
                    if (w_is_sync) begin
                        w_state_nx     = TRACK;
                        w_match_cnt_nx = 4'd1;
                        w_samp_cnt_nx  = 4'd1;
                        w_pred_nx      = lfsr_next(w_sample);
                    end
                end
                TRACK: begin
                    if (w_hit) begin
                        w_match_cnt_nx = w_match_inc;
                        w_pred_nx      = lfsr_next(w_sample);
                        if (w_match_inc == LOCK_TARGET) begin
                            w_state_nx = LOCKED;
                            w_lock_nx  = 1'b1;
                        end
                    end else begin
                        // The offending sample is dropped, even a 100; resync waits for the next one.
                        w_err_nx       = 1'b1;
                        w_err_cnt_nx   = w_err_cnt_inc;
                        w_state_nx     = SEEK;
                        w_match_cnt_nx = 4'd0;
                    end
                end
                LOCKED: begin
                    if (w_hit) begin
                        w_pred_nx = lfsr_next(w_sample);
                        w_wrap_nx = w_is_sync;
                    end else begin
                        w_err_nx       = 1'b1;
                        w_err_cnt_nx   = w_err_cnt_inc;
                        w_lock_nx      = 1'b0;
                        w_state_nx     = SEEK;
                        w_match_cnt_nx = 4'd0;
                    end
                end
                default: w_state_nx = SEEK;
            endcase

            // Period spans from one matched 100 to the next, counted in sampled edges.
            if ((r_state != SEEK) && w_hit) begin
                if (w_is_sync) begin
                    w_period_nx   = r_samp_cnt;
                    w_samp_cnt_nx = 4'd1;
                end else begin
                    w_samp_cnt_nx = w_samp_inc;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignment so every flop sees pre-edge values.
        if (i_reset) begin
            r_state     <= SEEK;
            r_pred      <= SYNC_STATE;
            r_match_cnt <= 4'd0;
            r_samp_cnt  <= 4'd0;
            r_lock      <= 1'b0;
            r_err       <= 1'b0;
            r_wrap      <= 1'b0;
            r_err_cnt   <= '0;
            r_period    <= 4'd0;
        end else begin
            r_state     <= w_state_nx;
            r_pred      <= w_pred_nx;
            r_match_cnt <= w_match_cnt_nx;
            r_samp_cnt  <= w_samp_cnt_nx;
            r_lock      <= w_lock_nx;
            r_err       <= w_err_nx;
            r_wrap      <= w_wrap_nx;
            r_err_cnt   <= w_err_cnt_nx;
            r_period    <= w_period_nx;
        end
    end

    assign o_lock    = r_lock;
    assign o_err     = r_err;
    assign o_wrap    = r_wrap;
    assign o_err_cnt = r_err_cnt;
    assign o_period  = r_period;

endmodule

// File: tb/tb_lfsr8_seq_monitor.sv
// Directed bench for lfsr8_seq_monitor: lock, wrap, period, error injection, EN gaps,
// saturation and reset, with expected values worked out by hand from the golden sequence.
module tb_lfsr8_seq_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       x2, x1, x0;
    logic       lock, err, wrap;
    logic [7:0] err_cnt;
    logic [3:0] period;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] gold [8] = '{3'b100, 3'b010, 3'b101, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
    logic [2:0] late [4] = '{3'b101, 3'b110, 3'b111, 3'b011};

    always #5 clk = ~clk;

    lfsr8_seq_monitor #(.LOCK_CNT(8), .ERR_W(8)) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_en      (en),
        .i_x2      (x2),
        .i_x1      (x1),
        .i_x0      (x0),
        .o_lock    (lock),
        .o_err     (err),
        .o_wrap    (wrap),
        .o_err_cnt (err_cnt),
        .o_period  (period)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample, clock it, and settle 1 time unit past the edge.
    task automatic drive(input logic e, input logic [2:0] x);
        en = e;
        {x2, x1, x0} = x;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic e_lock, input logic e_err,
                               input logic e_wrap, input logic [7:0] e_cnt, input logic [3:0] e_per);
        check({tag, ".lock"},    32'(lock),    32'(e_lock));
        check({tag, ".err"},     32'(err),     32'(e_err));
        check({tag, ".wrap"},    32'(wrap),    32'(e_wrap));
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'(e_cnt));
        check({tag, ".period"},  32'(period),  32'(e_per));
    endtask

    initial begin
        logic       el, ew;
        logic [3:0] ep;

        rst = 1'b1;
        en  = 1'b1;
        {x2, x1, x0} = 3'b111;

        // Reset held two cycles with active-looking input
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'b111);
            expect_outs($sformatf("reset%0d", i), 0, 0, 0, 8'd0, 4'd0);
        end
        rst = 1'b0;

        // Clean lock: LOCK after 8th sample, WRAP + PERIOD=8 on each following 100
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, gold[i % 8]);
            expect_outs($sformatf("clean%0d", i), (i >= 7), 0, (i >= 8 && i % 8 == 0),
                        8'd0, (i >= 8) ? 4'd8 : 4'd0);
        end

        // Error injection while locked: 110 where 101 expected
        drive(1'b1, 3'b010);
        expect_outs("inj_ok", 1, 0, 0, 8'd0, 4'd8);
        drive(1'b1, 3'b110);
        expect_outs("inj_err", 0, 1, 0, 8'd1, 4'd8);
        drive(1'b1, 3'b111);
        expect_outs("inj_seek", 0, 0, 0, 8'd1, 4'd8);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, gold[i % 8]);
            expect_outs($sformatf("relock%0d", i), (i >= 7), 0, (i == 8), 8'd1, 4'd8);
        end

        // Reset while locked clears everything after that edge
        rst = 1'b1;
        drive(1'b1, 3'b010);
        expect_outs("midlock_rst", 0, 0, 0, 8'd0, 4'd0);
        rst = 1'b0;

        // Late start: non-100 states before sync are not errors
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, late[i]);
            expect_outs($sformatf("late_pre%0d", i), 0, 0, 0, 8'd0, 4'd0);
        end
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, gold[i % 8]);
            expect_outs($sformatf("late%0d", i), (i >= 7), 0, (i == 8), 8'd0,
                        (i == 8) ? 4'd8 : 4'd0);
        end

        // Locked mismatch on a 100, then TRACK mismatch on a 100 that must be discarded
        drive(1'b1, 3'b100);
        expect_outs("lk_mis", 0, 1, 0, 8'd1, 4'd8);
        drive(1'b1, 3'b100);
        expect_outs("resync", 0, 0, 0, 8'd1, 4'd8);
        drive(1'b1, 3'b010);
        expect_outs("trk_ok", 0, 0, 0, 8'd1, 4'd8);
        drive(1'b1, 3'b100);
        expect_outs("trk_mis", 0, 1, 0, 8'd2, 4'd8);
        drive(1'b1, 3'b100);
        expect_outs("no_same_cycle_sync", 0, 0, 0, 8'd2, 4'd8);
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, gold[i]);
            expect_outs($sformatf("trk_relock%0d", i), (i == 7), 0, 0, 8'd2, 4'd8);
        end
        drive(1'b1, gold[0]);
        expect_outs("trk_wrap", 1, 0, 1, 8'd2, 4'd8);

        // EN gaps: each sampled edge followed by two EN=0 edges carrying junk
        rst = 1'b1;
        drive(1'b1, 3'b111);
        expect_outs("gap_rst", 0, 0, 0, 8'd0, 4'd0);
        rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            el = (k >= 7);
            ew = (k >= 8 && k % 8 == 0);
            ep = (k >= 8) ? 4'd8 : 4'd0;
            drive(1'b1, gold[k % 8]);
            expect_outs($sformatf("gap_s%0d", k), el, 0, ew, 8'd0, ep);
            for (int g = 0; g < 2; g++) begin
                drive(1'b0, gold[(k + 3) % 8]);
                expect_outs($sformatf("gap_h%0d_%0d", k, g), el, 0, 0, 8'd0, ep);
            end
        end

        // Saturation: 100,100 pairs each produce one TRACK mismatch
        rst = 1'b1;
        drive(1'b1, 3'b111);
        expect_outs("sat_rst", 0, 0, 0, 8'd0, 4'd0);
        rst = 1'b0;
        for (int n = 1; n <= 300; n++) begin
            drive(1'b1, 3'b100);
            check($sformatf("sat_sync%0d.err", n), 32'(err), 32'd0);
            drive(1'b1, 3'b100);
            check($sformatf("sat%0d.err", n), 32'(err), 32'd1);
            check($sformatf("sat%0d.err_cnt", n), 32'(err_cnt), (n > 255) ? 32'd255 : 32'(n));
        end
        expect_outs("sat_end", 0, 1, 0, 8'd255, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr8_seq_monitor.md
Name: lfsr8_seq_monitor

Overview:
- Sequence checker that sits directly downstream of the 3-bit, 8-state self-correcting LFSR counter.
- Samples the counter outputs X2, X1 and X0, synchronises to the start state 100, and predicts each next state from the counter's feedback function.
- Reports lock, mismatch errors, wrap events and the measured period.
- Used as the on-board health monitor for the counter and as the bench checker for it.

Parameters:
- LOCK_CNT, 8, consecutive matched samples (including the 100 sync sample) required to assert LOCK; legal range 2..15.
- ERR_W, 8, width of the saturating error counter.

Ports:
- CLK  in  1  rising-edge clock shared with the LFSR counter.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  sample enable; X2..X0 are sampled only on edges where EN=1.
- X2  in  1  counter state bit 2 (MSB, shift-in end).
- X1  in  1  counter state bit 1.
- X0  in  1  counter state bit 0.
- LOCK  out  1  sequence locked.
- ERR  out  1  one-cycle pulse on a mismatch.
- WRAP  out  1  one-cycle pulse when matched state 100 is seen while LOCKED.
- ERR_CNT  out  ERR_W  saturating mismatch count.
- PERIOD  out  4  samples between the last two matched 100 states, saturating at 15.

Behaviour:
- Next-state function for S={X2,X1,X0}:
  - next = {f, X2, X1}, where f = NOR(X2,X1) XOR X1 XOR X0.
  - Golden sequence: 100→010→101→110→111→011→001→000→100, period 8.
- Registers: state (SEEK/TRACK/LOCKED), pred[2:0], match_cnt[3:0], samp_cnt[3:0], plus the outputs.
- All outputs are registered. The effect of a sample taken on edge N is visible just after edge N (latency 1 edge).
- RESET (synchronous, wins over everything): state=SEEK, pred=100, match_cnt=0, samp_cnt=0, LOCK=0, ERR=0, WRAP=0, ERR_CNT=0, PERIOD=0.
- EN=0: all state, counters, LOCK, ERR_CNT and PERIOD hold; ERR and WRAP are driven 0.
- SEEK, sample=100: go to TRACK; match_cnt=1, samp_cnt=1, pred=010.
- SEEK, any other sample: stay in SEEK, no ERR (unsynchronised data is not an error).
- TRACK, sample==pred:
  - match_cnt+1, pred=next(sample).
  - If the new match_cnt == LOCK_CNT: go to LOCKED, LOCK=1.
- TRACK, sample!=pred: ERR=1, ERR_CNT+1 (saturating), go to SEEK; the sample is discarded (no same-cycle resync even if it is 100).
- LOCKED, sample==pred: stay; pred=next(sample). If sample==100, WRAP=1.
- LOCKED, sample!=pred: ERR=1, ERR_CNT+1 (saturating), LOCK=0, go to SEEK, match_cnt=0.
- Period measurement, in TRACK/LOCKED on each matched sample:
  - If sample==100: PERIOD=samp_cnt (saturating at 15), then samp_cnt=1.
  - Otherwise: samp_cnt+1, saturating at 15.
  - A healthy counter gives PERIOD=8.
- ERR_CNT saturates at 2^ERR_W−1 and never wraps. ERR still pulses at saturation.
- Reset during LOCKED: the next edge with RESET=1 clears everything. The first post-reset 100 restarts sync.
- LOCK, ERR and WRAP are never 1 together except LOCK with WRAP. ERR always coincides with LOCK falling or staying 0.

Test Plan:
- Reset check: hold RESET 2 cycles with X=111 and EN=1 → LOCK=0, ERR=0, WRAP=0, ERR_CNT=0, PERIOD=0; no change while RESET=1.
- Clean lock: EN=1 and feed the golden sequence from 100 →
  - LOCK rises after the 8th sample (000).
  - The 9th sample (100) gives WRAP=1 for one cycle and PERIOD=8.
  - WRAP repeats every 8 cycles with ERR=0.
- Error injection: while LOCKED, feed 110 where 101 is expected → ERR=1 for one cycle, ERR_CNT=1, LOCK=0. The next 100 restarts TRACK and LOCK returns 8 samples later.
- Late start: feed 101,110,111,011 before the first 100 → no ERR, LOCK=0 until 8 samples after that 100.
- EN gaps: golden sequence with EN toggling 1,0,0,1 → same LOCK/WRAP/PERIOD results counted in sampled edges; ERR and WRAP are 0 on EN=0 cycles.
- Saturation and mid-lock reset:
  - Repeated mismatches (e.g. 100 followed by 100, about 300 times) → ERR_CNT stops at 255.
  - Asserting RESET while LOCKED → all outputs return to 0 after that edge.
